// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the two-port memory arbiter: FSM state encoding,
// grant identifiers, latency-counter width and the default memory latency.
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    // Default backing-memory access latency in cycles (legal 1..15).
    localparam int MEM_LAT_DEFAULT = 4;

    // Counter width covering a load value of up to 14 (MEM_LAT-1).
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        ACK_I  = 3'd3,
        ACK_D  = 3'd4
    } state_t;

    // Identifies which port received the most recent grant.
    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

endpackage

// File: rtl/lat_counter.sv
// ---------------------------------------------------------------------------
// lat_counter
// Loadable down-counter that times one memory access.
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset, clears the count
//   load     : load load_val (has priority over counting)
//   load_val : value loaded at the start of an access
//   en       : decrement while non-zero
//   count    : current count
//   done     : count has reached zero
// ---------------------------------------------------------------------------
module lat_counter
    import mem_arb_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         done
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Arbitrates an instruction-fetch port and a data port onto one single-port
// memory with a fixed access latency. Round-robin when both ports contend.
//   clk, rst            : clock (rising edge), async active-high reset
//   if_req/if_addr      : fetch request (held until if_ack) and address
//   if_ack/if_rdata     : one-cycle completion pulse, fetched word (held)
//   d_re/d_we           : data read/write request (held until d_ack)
//   d_addr/d_wdata      : data address and write data
//   d_ack/d_rdata       : one-cycle completion pulse, read word (held)
//   mem_en/mem_wr       : memory enable and write strobe
//   mem_addr/mem_wdata  : memory address and write data
//   mem_rdata           : memory read data, valid at the last access cycle
//   freeze              : stall while any request is unacknowledged
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEFAULT,
    parameter int AW      = 16,
    parameter int DW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          d_re,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          freeze
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LAT - 1);

    state_t          state, state_nxt;
    grant_t          last_grant;
    logic            pend_i, pend_d;
    logic            grant_i, grant_d;
    logic            cnt_done;
    logic [CNT_W-1:0] cnt;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic            wr_q;

    assign pend_i = if_req;
    assign pend_d = d_re | d_we;

    // ---------------- next state, grant and outputs -----------------------
    // NOTE: every signal gets a default before the case so no path through
    // the block leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        if_ack    = 1'b0;
        d_ack     = 1'b0;

        unique case (state)
            IDLE: begin
                if (pend_i && pend_d) begin
                    // Contention: favour the port that was not served last.
                    if (last_grant == GNT_I) grant_d = 1'b1;
                    else                     grant_i = 1'b1;
                end else if (pend_d) begin
                    grant_d = 1'b1;
                end else if (pend_i) begin
                    grant_i = 1'b1;
                end
            end
            BUSY_I: begin
                mem_en = 1'b1;
                if (cnt_done) state_nxt = ACK_I;
            end
            BUSY_D: begin
                mem_en = 1'b1;
                mem_wr = wr_q;
                if (cnt_done) state_nxt = ACK_D;
            end
            // In an ACK cycle the acked port still shows its request, so only
            // the other port is considered; this also yields back-to-back
            // alternation when both ports stay busy.
            ACK_I: begin
                if_ack = 1'b1;
                if (pend_d) grant_d = 1'b1;
                else        state_nxt = IDLE;
            end
            ACK_D: begin
                d_ack = 1'b1;
                if (pend_i) grant_i = 1'b1;
                else        state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (grant_d)      state_nxt = BUSY_D;
        else if (grant_i) state_nxt = BUSY_I;
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign freeze = (if_req & ~if_ack) | ((d_re | d_we) & ~d_ack);

    // ---------------- state and access registers --------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GNT_I;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            state <= state_nxt;

            // Request fields are captured once at grant; later changes on
            // the request ports do not disturb the running access.
            if (grant_d) begin
                addr_q     <= d_addr;
                wdata_q    <= d_wdata;
                wr_q       <= d_we;     // d_re together with d_we is a write
                last_grant <= GNT_D;
            end else if (grant_i) begin
                addr_q     <= if_addr;
                wr_q       <= 1'b0;
                last_grant <= GNT_I;
            end

            if ((state == BUSY_I) && cnt_done) begin
                if_rdata <= mem_rdata;
            end
            if ((state == BUSY_D) && cnt_done && !wr_q) begin
                d_rdata <= mem_rdata;
            end
        end
    end

    lat_counter #(
        .W (CNT_W)
    ) u_lat_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (grant_i | grant_d),
        .load_val (LOAD_VAL),
        .en       (mem_en),
        .count    (cnt),
        .done     (cnt_done)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed stimulus for mem_arbiter (MEM_LAT=4). Each issued access pushes
// its expected memory beats and completion into queues; a monitor on the
// falling edge pops and compares whenever the DUT drives mem_en or an ack.
// The memory model returns addr ^ 0xBEFF only in the last beat of an access
// and 0xDEAD otherwise.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int MEM_LAT = 4;
    localparam int AW      = 16;
    localparam int DW      = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          d_re, d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          mem_en, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          freeze;

    mem_arbiter #(
        .MEM_LAT (MEM_LAT),
        .AW      (AW),
        .DW      (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .d_re      (d_re),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .freeze    (freeze)
    );

    always #5 clk = ~clk;

    // Cycle index: cycle N lies between rising edge N and N+1.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: data valid only in the final beat of an access.
    int beat = 0;
    always @(posedge clk) beat <= mem_en ? beat + 1 : 0;
    assign mem_rdata = (mem_en && beat == MEM_LAT - 1) ? (mem_addr ^ 16'hBEFF) : 16'hDEAD;

    // ---------------- scoreboard ----------------
    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] wdata;
    } beat_t;

    typedef struct {
        int            cyc;
        logic [DW-1:0] rdata;
    } ack_t;

    beat_t exp_beats[$];
    ack_t  exp_if[$];
    ack_t  exp_d[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // An access granted at the end of cycle start: beats start+1..start+MEM_LAT,
    // completion pulse at start+MEM_LAT+1.
    task automatic push_access(input bit is_d, input bit wr, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input int start,
                               input logic [DW-1:0] rdata);
        for (int b = 1; b <= MEM_LAT; b++) exp_beats.push_back('{start + b, addr, wr, wdata});
        if (is_d) exp_d.push_back('{start + MEM_LAT + 1, rdata});
        else      exp_if.push_back('{start + MEM_LAT + 1, rdata});
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        beat_t eb;
        ack_t  ea;
        if (mem_en) begin
            if (exp_beats.size() == 0) begin
                check("mem_beat_unexpected", 32'(mem_addr), 32'hFFFF_FFFF);
            end else begin
                eb = exp_beats.pop_front();
                check("beat_cycle", 32'(cyc), 32'(eb.cyc));
                check("beat_addr",  32'(mem_addr), 32'(eb.addr));
                check("beat_wr",    32'(mem_wr), 32'(eb.wr));
                if (eb.wr) check("beat_wdata", 32'(mem_wdata), 32'(eb.wdata));
            end
        end else begin
            check("mem_wr_idle", 32'(mem_wr), 32'd0);
        end
        if (if_ack) begin
            if (exp_if.size() == 0) begin
                check("if_ack_unexpected", 32'(if_ack), 32'd0);
            end else begin
                ea = exp_if.pop_front();
                check("if_ack_cycle", 32'(cyc), 32'(ea.cyc));
                check("if_rdata",     32'(if_rdata), 32'(ea.rdata));
            end
        end
        if (d_ack) begin
            if (exp_d.size() == 0) begin
                check("d_ack_unexpected", 32'(d_ack), 32'd0);
            end else begin
                ea = exp_d.pop_front();
                check("d_ack_cycle", 32'(cyc), 32'(ea.cyc));
                check("d_rdata",     32'(d_rdata), 32'(ea.rdata));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        cycles(1);
    endtask

    int k;

    initial begin
        rst     = 1'b1;
        if_req  = 1'b0;
        if_addr = '0;
        d_re    = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;

        cycles(2);
        check("rst_mem_en",    32'(mem_en),    32'd0);
        check("rst_mem_wr",    32'(mem_wr),    32'd0);
        check("rst_mem_addr",  32'(mem_addr),  32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_if_ack",    32'(if_ack),    32'd0);
        check("rst_d_ack",     32'(d_ack),     32'd0);
        check("rst_if_rdata",  32'(if_rdata),  32'd0);
        check("rst_d_rdata",   32'(d_rdata),   32'd0);
        check("rst_freeze",    32'(freeze),    32'd0);
        rst = 1'b0;
        cycles(2);

        // Fetch of 0x0010: beats 1-4, ack 5, data 0xBEEF; freeze 1 in 0-4.
        k = cyc;
        if_req = 1'b1; if_addr = 16'h0010;
        push_access(1'b0, 1'b0, 16'h0010, 16'h0000, k, 16'hBEEF);
        for (int j = 0; j <= 5; j++) begin
            @(negedge clk);
            check("freeze_fetch", 32'(freeze), (j < 5) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
        end
        if_req = 1'b0;
        cycles(2);
        check("if_rdata_hold", 32'(if_rdata), 32'hBEEF);

        // Write 0x1234 to 0x0200; d_rdata stays at its reset value.
        k = cyc;
        d_we = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234;
        push_access(1'b1, 1'b1, 16'h0200, 16'h1234, k, 16'h0000);
        cycles(6);
        d_we = 1'b0;
        cycles(2);

        // Read 0x0200 with the address changing to 0x0300 in cycle 2.
        k = cyc;
        d_re = 1'b1; d_addr = 16'h0200;
        push_access(1'b1, 1'b0, 16'h0200, 16'h0000, k, 16'hBCFF);
        cycles(2);
        d_addr = 16'h0300; d_wdata = 16'hFFFF;
        cycles(4);
        d_re = 1'b0;
        cycles(2);

        // d_re and d_we together behave as a write; d_rdata keeps 0xBCFF.
        k = cyc;
        d_re = 1'b1; d_we = 1'b1; d_addr = 16'h0044; d_wdata = 16'hCAFE;
        push_access(1'b1, 1'b1, 16'h0044, 16'hCAFE, k, 16'hBCFF);
        cycles(6);
        d_re = 1'b0; d_we = 1'b0;
        cycles(2);

        // Simultaneous fetch and data read after reset: data first.
        pulse_reset();
        k = cyc;
        if_req = 1'b1; if_addr = 16'h0040;
        d_re   = 1'b1; d_addr  = 16'h0080;
        push_access(1'b1, 1'b0, 16'h0080, 16'h0000, k,     16'hBE7F);
        push_access(1'b0, 1'b0, 16'h0040, 16'h0000, k + 5, 16'hBEBF);
        cycles(6);
        d_re = 1'b0;
        cycles(5);
        if_req = 1'b0;
        cycles(2);

        // Both ports held over four accesses: D, I, D, I with no idle gap.
        pulse_reset();
        k = cyc;
        if_req = 1'b1; if_addr = 16'h0100;
        d_re   = 1'b1; d_addr  = 16'h0222;
        push_access(1'b1, 1'b0, 16'h0222, 16'h0000, k,      16'hBCDD);
        push_access(1'b0, 1'b0, 16'h0100, 16'h0000, k + 5,  16'hBFFF);
        push_access(1'b1, 1'b0, 16'h0222, 16'h0000, k + 10, 16'hBCDD);
        push_access(1'b0, 1'b0, 16'h0100, 16'h0000, k + 15, 16'hBFFF);
        cycles(16);
        d_re = 1'b0;
        cycles(5);
        if_req = 1'b0;
        cycles(2);

        // Reset in cycle 2 of a data read aborts it; the held request restarts.
        check("d_rdata_before_abort", 32'(d_rdata), 32'hBCDD);
        k = cyc;
        d_re = 1'b1; d_addr = 16'h0300;
        exp_beats.push_back('{k + 1, 16'h0300, 1'b0, 16'h0000});
        cycles(2);
        rst = 1'b1;
        #1;
        check("abort_mem_en",   32'(mem_en),   32'd0);
        check("abort_mem_addr", 32'(mem_addr), 32'd0);
        check("abort_d_ack",    32'(d_ack),    32'd0);
        check("abort_d_rdata",  32'(d_rdata),  32'd0);
        check("abort_freeze",   32'(freeze),   32'd1);
        cycles(1);
        rst = 1'b0;
        push_access(1'b1, 1'b0, 16'h0300, 16'h0000, k + 3, 16'hBDFF);
        cycles(6);
        d_re = 1'b0;
        cycles(3);

        check("left_beats",   32'(exp_beats.size()), 32'd0);
        check("left_if_acks", 32'(exp_if.size()),    32'd0);
        check("left_d_acks",  32'(exp_d.size()),     32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
